// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-port memory-to-memory word copier.
// Moves len_i 32-bit words from src to dst over a req/gnt/rvalid port.
// Only one transaction is outstanding at a time: read, then write, per word.
module mem_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 mem_en_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    state_t               r_state, w_next;
    logic [31:0]          r_src, r_dst, r_buf;
    logic [LEN_WIDTH-1:0] r_rem;
    logic                 r_abort, r_err;
    logic                 w_misaligned, w_abort_any, w_active;

    assign w_misaligned = (|src_addr_i[1:0]) | (|dst_addr_i[1:0]);
    // An abort seen in an earlier cycle still counts when the response lands.
    assign w_abort_any  = abort_i | r_abort;
    assign w_active     = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                          (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode; a grant beats a same-cycle abort in the REQ states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && !w_misaligned)
                    w_next = (len_i == '0) ? S_DONE : S_RD_REQ;
            end
            S_RD_REQ: begin
                if (mem_gnt_i)    w_next = S_RD_WAIT;
                else if (abort_i) w_next = S_IDLE;
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) w_next = w_abort_any ? S_IDLE : S_WR_REQ;
            end
            S_WR_REQ: begin
                if (mem_gnt_i)    w_next = S_WR_WAIT;
                else if (abort_i) w_next = S_IDLE;
            end
            S_WR_WAIT: begin
                if (mem_rvalid_i) begin
                    if (w_abort_any)                      w_next = S_IDLE;
                    else if (r_rem == LEN_WIDTH'(1))      w_next = S_DONE;
                    else                                  w_next = S_RD_REQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pointers, word count, data buffer, abort latch and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && start_i && w_misaligned;
            if (r_state == S_IDLE && start_i && !w_misaligned && len_i != '0) begin
                r_src <= src_addr_i;
                r_dst <= dst_addr_i;
                r_rem <= len_i;
            end
            if (!w_active)         r_abort <= 1'b0;
            else if (abort_i)      r_abort <= 1'b1;
            if (r_state == S_RD_WAIT && mem_rvalid_i)
                r_buf <= mem_rdata_i;
            // Pointers wrap modulo 2^32 by plain 32-bit addition.
            if (r_state == S_WR_WAIT && mem_rvalid_i) begin
                r_src <= r_src + 32'd4;
                r_dst <= r_dst + 32'd4;
                r_rem <= r_rem - LEN_WIDTH'(1);
            end
        end
    end

    // Moore output decode.
    always_comb begin
        busy_o      = w_active;
        done_o      = (r_state == S_DONE);
        err_o       = r_err;
        mem_req_o   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
        mem_en_o    = mem_req_o;
        mem_we_o    = (r_state == S_WR_REQ);
        mem_be_o    = mem_req_o ? 4'b1111 : 4'b0000;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        if (r_state == S_RD_REQ) mem_addr_o = r_src;
        if (r_state == S_WR_REQ) begin
            mem_addr_o  = r_dst;
            mem_wdata_o = r_buf;
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed scoreboard bench for mem_copy_dma with a RAM responder.
module tb_mem_copy_dma;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic [31:0] src_addr_i = '0, dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o, mem_en_o, mem_req_o, mem_we_o;
    logic        mem_gnt_i, mem_rvalid_i = 1'b0;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;

    mem_copy_dma #(.LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_en_o(mem_en_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;

    typedef struct {
        int          kind;   // 0 bus request, 1 done, 2 err
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Source memory contents, fixed by hand.
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            32'h0000_0108: return 32'h3333_3333;
            32'h0000_010C: return 32'h4444_4444;
            32'hFFFF_FFF8: return 32'hCAFE_0001;
            32'hFFFF_FFFC: return 32'hCAFE_0002;
            32'h0000_0000: return 32'hCAFE_0003;
            default:       return 32'hA500_0000 | a;
        endcase
    endfunction

    // Responder: combinational grant (optionally stalled), rvalid one cycle later.
    logic [31:0] wr_mem [logic [31:0]];
    logic [31:0] stall_addr = 32'h0000_0204;
    logic        stall_arm = 1'b0;
    int          stall_cnt = 0;
    logic        w_block;
    assign w_block   = mem_req_o && mem_we_o && (mem_addr_o == stall_addr) && (stall_cnt != 0);
    assign mem_gnt_i = mem_req_o && !w_block;

    initial forever begin
        @(posedge clk_i);
        if (stall_arm)    stall_cnt <= 3;
        else if (w_block) stall_cnt <= stall_cnt - 1;
        mem_rvalid_i <= mem_req_o && mem_gnt_i;
        if (mem_req_o && mem_gnt_i) begin
            if (mem_we_o) wr_mem[mem_addr_o] = mem_wdata_o;
            else          mem_rdata_i <= rd_model(mem_addr_o);
        end
    end

    function automatic logic [31:0] get_wr(input logic [31:0] a);
        return wr_mem.exists(a) ? wr_mem[a] : 32'hDEAD_BEEF;
    endfunction

    // Monitor: pops one expected event per DUT presentation.
    task automatic sb(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected kind=%0d addr=%h required=none", kind, mem_addr_o);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (kind == 0 && e.kind == 0) begin
                chk("sb_we", 32'(mem_we_o), 32'(e.we));
                chk("sb_addr", mem_addr_o, e.addr);
                chk("sb_be", 32'(mem_be_o), 32'hF);
                chk("sb_en", 32'(mem_en_o), 32'h1);
                if (e.we) chk("sb_wdata", mem_wdata_o, e.data);
            end
        end
    endtask

    initial begin
        logic        p_stall;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        p_stall = 1'b0; p_addr = '0; p_wdata = '0; p_we = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                exp_q.delete();
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    chk("stall_req", 32'(mem_req_o), 32'h1);
                    chk("stall_addr", mem_addr_o, p_addr);
                    chk("stall_we", 32'(mem_we_o), 32'(p_we));
                    chk("stall_wdata", mem_wdata_o, p_wdata);
                end
                p_stall = mem_req_o && !mem_gnt_i;
                p_addr = mem_addr_o; p_we = mem_we_o; p_wdata = mem_wdata_o;
                if (mem_req_o && mem_gnt_i) sb(0);
                if (done_o) sb(1);
                if (err_o)  sb(2);
            end
        end
    end

    function automatic void exp_rd(input logic [31:0] a);
        exp_q.push_back('{0, 1'b0, a, 32'h0});
    endfunction
    function automatic void exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{0, 1'b1, a, d});
    endfunction
    function automatic void exp_ev(input int k);
        exp_q.push_back('{k, 1'b0, 32'h0, 32'h0});
    endfunction

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk_i); #1;
        src_addr_i = s; dst_addr_i = d; len_i = l; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Watches win cycles after the start edge; cycle 1 is the one right after it.
    task automatic observe(input int win, output int done_at, output int n_done,
                           output int n_busy, output int n_req, output int err_at);
        done_at = 0; n_done = 0; n_busy = 0; n_req = 0; err_at = 0;
        for (int n = 1; n <= win; n++) begin
            @(negedge clk_i);
            if (done_o) begin n_done++; if (done_at == 0) done_at = n; end
            if (err_o && err_at == 0) err_at = n;
            if (busy_o) n_busy++;
            if (mem_req_o) n_req++;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 32'({busy_o, done_o, err_o, mem_req_o, mem_en_o, mem_we_o, mem_be_o}), 32'h0);
        chk({name, "_addr"}, mem_addr_o, 32'h0);
        chk({name, "_wdata"}, mem_wdata_o, 32'h0);
    endtask

    task automatic exp_copy4(input logic [31:0] d);
        exp_rd(32'h100); exp_wr(d,        32'h1111_1111);
        exp_rd(32'h104); exp_wr(d + 32'h4, 32'h2222_2222);
        exp_rd(32'h108); exp_wr(d + 32'h8, 32'h3333_3333);
        exp_rd(32'h10C); exp_wr(d + 32'hC, 32'h4444_4444);
        exp_ev(1);
    endtask

    initial begin
        int dn, nd, nb, nr, ea;
        bit found;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1 chk_all_zero("reset");
        rst_ni = 1'b1;

        // Plain 4-word copy
        exp_copy4(32'h200);
        do_start(32'h100, 32'h200, 16'd4);
        observe(25, dn, nd, nb, nr, ea);
        chk("copy_done_at", 32'(dn), 32'd17);
        chk("copy_done_cnt", 32'(nd), 32'd1);
        chk("copy_busy_cycles", 32'(nb), 32'd16);
        chk("copy_ram200", get_wr(32'h200), 32'h1111_1111);
        chk("copy_ram20C", get_wr(32'h20C), 32'h4444_4444);

        // Zero length
        exp_ev(1);
        do_start(32'h100, 32'h200, 16'd0);
        observe(5, dn, nd, nb, nr, ea);
        chk("zero_done_at", 32'(dn), 32'd1);
        chk("zero_req", 32'(nr), 32'd0);
        chk("zero_busy", 32'(nb), 32'd0);

        // Misaligned source, then destination
        for (int k = 0; k < 2; k++) begin
            exp_ev(2);
            do_start(k == 0 ? 32'h102 : 32'h100, k == 0 ? 32'h200 : 32'h201, 16'd4);
            observe(5, dn, nd, nb, nr, ea);
            chk("mis_err_at", 32'(ea), 32'd1);
            chk("mis_req", 32'(nr), 32'd0);
            chk("mis_busy", 32'(nb), 32'd0);
            chk("mis_done", 32'(nd), 32'd0);
        end

        // Grant stall on the write of word 2 (dst 0x204)
        @(posedge clk_i); #1 stall_arm = 1'b1;
        @(posedge clk_i); #1 stall_arm = 1'b0;
        exp_copy4(32'h200);
        do_start(32'h100, 32'h200, 16'd4);
        observe(30, dn, nd, nb, nr, ea);
        chk("stall_done_at", 32'(dn), 32'd20);
        chk("stall_done_cnt", 32'(nd), 32'd1);

        // Abort during the read wait of word 3
        exp_rd(32'h300); exp_wr(32'h400, 32'hA500_0300);
        exp_rd(32'h304); exp_wr(32'h404, 32'hA500_0304);
        exp_rd(32'h308);
        do_start(32'h300, 32'h400, 16'd8);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk_i);
            if (mem_req_o && mem_gnt_i && !mem_we_o && mem_addr_o == 32'h308) found = 1'b1;
        end
        chk("abort_reached_word3", 32'(found), 32'h1);
        @(posedge clk_i); #1 abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        observe(10, dn, nd, nb, nr, ea);
        chk("abort_no_done", 32'(nd), 32'd0);
        chk("abort_idle_busy", 32'(nb), 32'd0);
        chk("abort_no_req", 32'(nr), 32'd0);
        chk("abort_ram404", get_wr(32'h404), 32'hA500_0304);
        chk("abort_ram408", get_wr(32'h408), 32'hDEAD_BEEF);
        exp_rd(32'h100); exp_wr(32'h600, 32'h1111_1111);
        exp_rd(32'h104); exp_wr(32'h604, 32'h2222_2222);
        exp_ev(1);
        do_start(32'h100, 32'h600, 16'd2);
        observe(12, dn, nd, nb, nr, ea);
        chk("after_abort_done_at", 32'(dn), 32'd9);
        chk("after_abort_ram604", get_wr(32'h604), 32'h2222_2222);

        // Reset in the middle of a copy
        exp_copy4(32'h700);
        do_start(32'h100, 32'h700, 16'd4);
        repeat (6) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1 chk_all_zero("midreset");
        @(posedge clk_i); @(posedge clk_i); #1 rst_ni = 1'b1;
        observe(4, dn, nd, nb, nr, ea);
        chk("midreset_quiet", 32'(nr + nb + nd), 32'd0);

        // Source pointer wrap
        exp_rd(32'hFFFF_FFF8); exp_wr(32'h500, 32'hCAFE_0001);
        exp_rd(32'hFFFF_FFFC); exp_wr(32'h504, 32'hCAFE_0002);
        exp_rd(32'h0000_0000); exp_wr(32'h508, 32'hCAFE_0003);
        exp_ev(1);
        do_start(32'hFFFF_FFF8, 32'h500, 16'd3);
        observe(18, dn, nd, nb, nr, ea);
        chk("wrap_done_at", 32'(dn), 32'd13);
        chk("wrap_ram508", get_wr(32'h508), 32'hCAFE_0003);

        repeat (2) @(negedge clk_i);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
